// File: rtl/addsub_pkg.sv
// Shared FSM state type, mode encodings and width helper for the serial add/sub unit.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/addsub_digit.sv
// Combinational DIGIT-bit ripple-carry slice; also exposes the carry into its top bit
// so the caller can derive signed overflow on the most significant digit.
module addsub_digit
    import addsub_pkg::*;
#(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] i_a,
    input  logic [DIGIT-1:0] i_b,
    input  logic             i_cin,
    output logic [DIGIT-1:0] o_sum,
    output logic             o_cout,
    output logic             o_c_msb_in
);

    logic [DIGIT:0] w_c;

    always_comb begin
        w_c    = '0;
        o_sum  = '0;
        w_c[0] = i_cin;
        for (int i = 0; i < DIGIT; i++) begin
            o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
            w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
        end
    end

    assign o_cout     = w_c[DIGIT];
    assign o_c_msb_in = w_c[DIGIT-1];

endmodule

// File: rtl/serial_addsub_unit.sv
// Digit-serial add/subtract unit with valid/ready on both sides.
// Define ADDSUB_SAT_EN to saturate the result on signed overflow.
module serial_addsub_unit
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output state_t           o_state
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (clog2(N) < 1) ? 1 : clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic             r_mode;
    logic             r_cout;
    logic             r_ovf;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [CW-1:0]    r_cnt;

    logic [DIGIT-1:0] w_sum;
    logic             w_cout;
    logic             w_c_msb_in;
    logic             w_ovf;
    logic [WIDTH-1:0] w_acc_next;
    logic [WIDTH-1:0] w_result_fin;

    addsub_digit #(.DIGIT(DIGIT)) u_digit (
        .i_a        (r_a[DIGIT-1:0]),
        .i_b        (r_b[DIGIT-1:0]),
        .i_cin      (r_carry),
        .o_sum      (w_sum),
        .o_cout     (w_cout),
        .o_c_msb_in (w_c_msb_in)
    );

    // Only meaningful on the last RUN cycle, when the slice holds the top digit.
    assign w_ovf = w_cout ^ w_c_msb_in;

    // Partial sum fills from the top, so after N digits it is already in place.
    generate
        if (DIGIT == WIDTH) begin : g_single
            assign w_acc_next = w_sum;
        end else begin : g_multi
            logic [WIDTH-DIGIT-1:0] r_acc;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_acc <= '0;
                end else if (r_state == RUN) begin
                    r_acc <= w_acc_next[WIDTH-1:DIGIT];
                end
            end
            assign w_acc_next = {w_sum, r_acc};
        end
    endgenerate

`ifdef ADDSUB_SAT_EN
    // A wrapped MSB of 1 means the true value overflowed positive, and vice versa.
    assign w_result_fin = w_ovf ? {~w_acc_next[WIDTH-1], {(WIDTH-1){w_acc_next[WIDTH-1]}}}
                                : w_acc_next;
`else
    assign w_result_fin = w_acc_next;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_result    <= '0;
            r_carry     <= 1'b0;
            r_mode      <= MODE_ADD;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_a        <= a;
                        r_b        <= b ^ {WIDTH{mode}};
                        r_mode     <= mode;
                        r_carry    <= cin ^ mode;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    r_a     <= r_a >> DIGIT;
                    r_b     <= r_b >> DIGIT;
                    r_carry <= w_cout;
                    r_cnt   <= r_cnt + ONE;
                    if (r_cnt == LAST) begin
                        r_cnt       <= '0;
                        r_result    <= w_result_fin;
                        r_cout      <= (r_mode == MODE_SUB) ? ~w_cout : w_cout;
                        r_ovf       <= w_ovf;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign o_state   = r_state;

endmodule

// File: tb/tb_serial_addsub_unit.sv
// Bench for serial_addsub_unit: directed vector table, hand sequences, and random/exhaustive
// runs on three configurations (16/4, 4/1, 16/16) against an integer reference model.
module tb_serial_addsub_unit;
    import addsub_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        mode;
    logic        in_valid;
    logic        out_ready;
    int          sel;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    logic        rdy0, val0, co0, ov0;
    logic [15:0] res0;
    state_t      st0;
    logic        rdy1, val1, co1, ov1;
    logic [3:0]  res1;
    state_t      st1;
    logic        rdy2, val2, co2, ov2;
    logic [15:0] res2;
    state_t      st2;

    serial_addsub_unit #(.WIDTH(16), .DIGIT(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid && (sel == 0)), .in_ready(rdy0),
        .a(a), .b(b), .cin(cin), .mode(mode), .out_valid(val0), .out_ready(out_ready),
        .result(res0), .cout(co0), .ovf(ov0), .o_state(st0)
    );

    serial_addsub_unit #(.WIDTH(4), .DIGIT(1)) u_w4 (
        .clk(clk), .rst(rst), .in_valid(in_valid && (sel == 1)), .in_ready(rdy1),
        .a(a[3:0]), .b(b[3:0]), .cin(cin), .mode(mode), .out_valid(val1), .out_ready(out_ready),
        .result(res1), .cout(co1), .ovf(ov1), .o_state(st1)
    );

    serial_addsub_unit #(.WIDTH(16), .DIGIT(16)) u_d16 (
        .clk(clk), .rst(rst), .in_valid(in_valid && (sel == 2)), .in_ready(rdy2),
        .a(a), .b(b), .cin(cin), .mode(mode), .out_valid(val2), .out_ready(out_ready),
        .result(res2), .cout(co2), .ovf(ov2), .o_state(st2)
    );

    logic [15:0] s_result;
    logic        s_cout, s_ovf, s_in_ready, s_out_valid;
    state_t      s_state;

    always_comb begin
        s_result    = res0;
        s_cout      = co0;
        s_ovf       = ov0;
        s_in_ready  = rdy0;
        s_out_valid = val0;
        s_state     = st0;
        case (sel)
            1: begin
                s_result    = {12'd0, res1};
                s_cout      = co1;
                s_ovf       = ov1;
                s_in_ready  = rdy1;
                s_out_valid = val1;
                s_state     = st1;
            end
            2: begin
                s_result    = res2;
                s_cout      = co2;
                s_ovf       = ov2;
                s_in_ready  = rdy2;
                s_out_valid = val2;
                s_state     = st2;
            end
            default: ;
        endcase
    end

    function automatic int width_of(input int s);
        return (s == 1) ? 4 : 16;
    endfunction

    function automatic int digits_of(input int s);
        return (s == 2) ? 1 : 4;
    endfunction

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    function automatic void model(input int w, input logic [15:0] ai, input logic [15:0] bi,
                                  input logic ci, input logic mi, output logic [15:0] res,
                                  output logic co, output logic ov);
        longint lim, ua, ub, sa, sb, u, s;
        lim = longint'(1) << (w - 1);
        ua  = longint'(ai) & (2 * lim - 1);
        ub  = longint'(bi) & (2 * lim - 1);
        sa  = (ua >= lim) ? ua - 2 * lim : ua;
        sb  = (ub >= lim) ? ub - 2 * lim : ub;
        if (mi == 1'b0) begin
            u  = ua + ub + longint'(ci);
            s  = sa + sb + longint'(ci);
            co = (u >= 2 * lim);
        end else begin
            u  = ua - ub - longint'(ci);
            s  = sa - sb - longint'(ci);
            co = (u < 0);
        end
        ov  = (s >= lim) || (s < -lim);
        res = 16'(u & (2 * lim - 1));
`ifdef ADDSUB_SAT_EN
        if (ov) res = (s >= lim) ? 16'(lim - 1) : 16'(lim);
`endif
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction on the selected instance; operands are scrambled during RUN.
    task automatic do_op(input logic [15:0] ai, input logic [15:0] bi, input logic ci,
                         input logic mi, input logic [15:0] er, input logic ec,
                         input logic eo, input int hold, input string nm);
        int lat;
        int wt;
        wt = 0;
        while (!s_in_ready && wt < 50) begin
            tick();
            wt++;
        end
        check({nm, "_in_ready_idle"}, 32'(s_in_ready), 32'd1);
        a = ai; b = bi; cin = ci; mode = mi; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!s_out_valid && lat < 100) begin
            a    = 16'($urandom);
            b    = 16'($urandom);
            cin  = 1'($urandom_range(0, 1));
            mode = 1'($urandom_range(0, 1));
            tick();
            lat++;
        end
        check({nm, "_latency"}, 32'(lat), 32'(digits_of(sel)));
        check({nm, "_result"}, 32'(s_result), 32'(er));
        check({nm, "_cout"}, 32'(s_cout), 32'(ec));
        check({nm, "_ovf"}, 32'(s_ovf), 32'(eo));
        check({nm, "_in_ready_busy"}, 32'(s_in_ready), 32'd0);
        for (int h = 0; h < hold; h++) begin
            tick();
            check({nm, "_hold"}, {12'd0, s_out_valid, s_in_ready, s_cout, s_ovf, s_result},
                  {12'd0, 1'b1, 1'b0, ec, eo, er});
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({nm, "_handoff"}, {30'd0, s_out_valid, s_in_ready}, {30'd0, 1'b0, 1'b1});
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        mode;
        logic [15:0] res;
        logic        co;
        logic        ov;
    } vec_t;

`ifdef ADDSUB_SAT_EN
    localparam logic [15:0] R_POS_OVF = 16'h7FFF;
    localparam logic [15:0] R_NEG_OVF = 16'h8000;
    localparam logic [15:0] R_MIN_MIN = 16'h8000;
`else
    localparam logic [15:0] R_POS_OVF = 16'h8000;
    localparam logic [15:0] R_NEG_OVF = 16'h7FFF;
    localparam logic [15:0] R_MIN_MIN = 16'h0000;
`endif

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not reach the summary in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        vecs[8];
        logic [15:0] er;
        logic        ec, eo;
        int          acc_q[$];
        int          wt;

        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000,  1'b1, 1'b0};
        vecs[1] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE,  1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, R_POS_OVF, 1'b0, 1'b1};
        vecs[3] = '{16'h8000, 16'h0001, 1'b0, 1'b1, R_NEG_OVF, 1'b0, 1'b1};
        vecs[4] = '{16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346,  1'b0, 1'b0};
        vecs[5] = '{16'h1234, 16'h1111, 1'b1, 1'b1, 16'h0122,  1'b0, 1'b0};
        vecs[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, R_MIN_MIN, 1'b1, 1'b1};
        vecs[7] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF,  1'b1, 1'b0};

        rst = 1'b1; a = '0; b = '0; cin = 1'b0; mode = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; sel = 0;
        repeat (3) tick();
        check("reset_state", 32'(s_state), 32'(IDLE));
        check("reset_flags", {28'd0, s_in_ready, s_out_valid, s_cout, s_ovf},
              {28'd0, 1'b1, 1'b0, 1'b0, 1'b0});
        check("reset_result", 32'(s_result), 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].mode, vecs[i].res,
                  vecs[i].co, vecs[i].ov, (i == 0) ? 10 : $urandom_range(0, 2),
                  $sformatf("vec%0d", i));
        end

        // Reset during the second RUN cycle discards the operation.
        a = 16'h1234; b = 16'h0001; cin = 1'b0; mode = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check("midrun_state_before", 32'(s_state), 32'(RUN));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrun_rst_state", 32'(s_state), 32'(IDLE));
        check("midrun_rst_flags", {28'd0, s_in_ready, s_out_valid, s_cout, s_ovf},
              {28'd0, 1'b1, 1'b0, 1'b0, 1'b0});
        check("midrun_rst_result", 32'(s_result), 32'd0);
        model(16, 16'h4321, 16'h1234, 1'b0, 1'b1, er, ec, eo);
        do_op(16'h4321, 16'h1234, 1'b0, 1'b1, er, ec, eo, 0, "after_rst");

        // Back-to-back requests with the consumer always ready.
        out_ready = 1'b1;
        a = 16'h0101; b = 16'h0202; cin = 1'b0; mode = 1'b0; in_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (s_in_ready) acc_q.push_back(c);
            tick();
        end
        in_valid = 1'b0;
        wt = 0;
        while (s_state != IDLE && wt < 20) begin
            tick();
            wt++;
        end
        out_ready = 1'b0;
        check("tput_accepts", 32'(acc_q.size()), 32'd4);
        for (int i = 1; i < acc_q.size(); i++) begin
            check("tput_period", 32'(acc_q[i] - acc_q[i-1]), 32'd6);
        end

        // Random operations on the 16/4 configuration.
        for (int i = 0; i < 40; i++) begin
            logic [15:0] ra, rb;
            logic        rc, rm;
            ra = 16'($urandom); rb = 16'($urandom);
            rc = 1'($urandom_range(0, 1)); rm = 1'($urandom_range(0, 1));
            if (i % 8 == 0) rb = (ra ^ 16'h8000);
            model(16, ra, rb, rc, rm, er, ec, eo);
            do_op(ra, rb, rc, rm, er, ec, eo, $urandom_range(0, 3), "rand16x4");
        end

        // Single-cycle digit configuration.
        sel = 2;
        for (int i = 0; i < 30; i++) begin
            logic [15:0] ra, rb;
            logic        rc, rm;
            ra = 16'($urandom); rb = 16'($urandom);
            rc = 1'($urandom_range(0, 1)); rm = 1'($urandom_range(0, 1));
            model(width_of(sel), ra, rb, rc, rm, er, ec, eo);
            do_op(ra, rb, rc, rm, er, ec, eo, $urandom_range(0, 2), "rand16x16");
        end

        // Exhaustive 4-bit sweep, one bit per cycle.
        sel = 1;
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                for (int k = 0; k < 4; k++) begin
                    model(width_of(sel), 16'(x), 16'(y), k[0], k[1], er, ec, eo);
                    do_op(16'(x), 16'(y), k[0], k[1], er, ec, eo, 0, "sweep4x1");
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
